booth_div: RTL
==============

Name: booth_div

Overview:
- Sequential signed divider, the inverse of the team's radix-4 Booth multiplier (bm).
- Takes a 2*WIDTH-bit two's-complement dividend (a bm product width) and a WIDTH-bit signed divisor.
- Returns a WIDTH-bit quotient and a WIDTH-bit remainder via restoring radix-2 iteration on magnitudes, one quotient bit per clock.
- Sits beside bm in the arithmetic datapath and uses a start/done handshake.

Parameters:
- WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2*WIDTH  signed dividend, captured on accepted start
- divisor  input  WIDTH  signed divisor, captured on accepted start
- busy  output  1  high from the edge after start is accepted until done
- done  output  1  one-cycle pulse when results are valid
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder, same sign as dividend (or zero)
- div_by_zero  output  1  divisor was 0 for this operation
- overflow  output  1  true quotient is outside the signed WIDTH range

Behaviour:
- Reset (reset_n=0 at an edge): state IDLE, iteration counter 0; busy, done, quotient, remainder, div_by_zero and overflow all 0.
- Reset mid-operation aborts the operation: no done pulse, registers cleared as above.
- FSM states: IDLE, CALC, FIX.
- IDLE: when start=1 at edge k:
  - capture sign_q = dividend MSB XOR divisor MSB and sign_r = dividend MSB;
  - capture the magnitudes |dividend| (2*WIDTH-bit unsigned; -2^(2W-1) maps to 2^(2W-1)) and |divisor| (WIDTH-bit unsigned);
  - busy=1;
  - if divisor==0, go to FIX; else go to CALC with counter 0.
- CALC, 2*WIDTH cycles (edges k+1..k+2*WIDTH):
  - partial remainder is (WIDTH+1) bits: shift left, bring in the next dividend-magnitude MSB, then trial-subtract |divisor|;
  - if the result is non-negative, keep it and the quotient bit is 1; else restore and the quotient bit is 0;
  - after the last iteration (counter = 2*WIDTH-1), go to FIX.
- FIX (one edge: k+2*WIDTH+1 normally, k+1 for divide-by-zero):
  - apply signs: q = sign_q ? -|q| : |q|; r = sign_r ? -|r| : |r|;
  - overflow = 1 if sign_q=0 and |q|>2^(WIDTH-1)-1, or sign_q=1 and |q|>2^(WIDTH-1);
  - quotient = low WIDTH bits of the signed true quotient (also when overflow=1);
  - remainder always fits in WIDTH bits;
  - divide-by-zero: quotient=0, remainder=dividend[WIDTH-1:0], div_by_zero=1, overflow=0;
  - register the outputs, set done=1 and busy=0, go to IDLE.
- Latency: done is high in the cycle after edge k+2*WIDTH+1 (17 edges for WIDTH=8); divide-by-zero gives done after edge k+1.
- done lasts exactly one cycle.
- Result outputs hold until the next FIX, or until reset.
- start while busy is ignored, with no queuing.
- start in the same cycle done is high is accepted, because the FSM is already in IDLE.
- Dividend and divisor inputs may change freely after capture.

Decomposition:
- Package booth_div_pkg holds:
  - the state enum (IDLE, CALC, FIX);
  - the WIDTH default;
  - a 2*WIDTH localparam;
  - the signed min/max quotient-bound constants.
- One natural sub-module, div_sign_fix: combinational negate/abs and overflow compare, used for input conditioning and in FIX.

Test Plan:
- 100 / 7 -> quotient 14, remainder 2, overflow 0; done exactly 17 edges after the start edge, busy high throughout.
- -100 / 7 -> quotient -14 (0xF2), remainder -2 (0xFE).
- 1000 / -8 -> quotient -125 (0x83), remainder 0.
- 16256 / -128 -> quotient -127 (0x81), remainder 0, overflow 0.
- -16384 / -128 -> overflow 1, quotient 0x80.
- -32768 / 1 -> overflow 1.
- 500 / 0 -> done after 1 edge, div_by_zero 1, quotient 0, remainder 0xF4.
- Protocol:
  - start pulsed again mid-CALC -> ignored, first result unchanged;
  - reset_n low at CALC iteration 5 -> no done, all outputs 0, next start runs normally;
  - back-to-back start during done -> second result 17 edges later.

Source files
------------

// File: rtl/booth_div_pkg.sv
// booth_div_pkg: shared state encoding and width constants for the signed divider
package booth_div_pkg;
    localparam int WIDTH = 8;
    localparam int DWIDTH = 2 * WIDTH;
    localparam logic [DWIDTH-1:0] Q_MAX = DWIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic [DWIDTH-1:0] Q_MIN_MAG = DWIDTH'(1 << (WIDTH - 1));
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/booth_div_sign_fix.sv
// div_sign_fix: operand magnitudes on entry, signed results and overflow on exit
module div_sign_fix
    import booth_div_pkg::*;
#(
    parameter int W = booth_div_pkg::WIDTH
) (
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    input  logic [2*W-1:0] q_mag,
    input  logic [W-1:0]   r_mag,
    input  logic           sign_q,
    input  logic           sign_r,
    output logic [2*W-1:0] dividend_mag,
    output logic [W-1:0]   divisor_mag,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           overflow
);
    localparam logic [2*W-1:0] q_pos_max = (2*W)'((1 << (W - 1)) - 1);
    localparam logic [2*W-1:0] q_neg_max = (2*W)'(1 << (W - 1));
    // negation is modulo 2^n, so the most negative input maps onto its own unsigned magnitude
    always_comb begin
        dividend_mag = dividend[2*W-1] ? -dividend : dividend;
        divisor_mag  = divisor[W-1] ? -divisor : divisor;
        quotient     = sign_q ? -q_mag[W-1:0] : q_mag[W-1:0];
        remainder    = sign_r ? -r_mag : r_mag;
        overflow     = q_mag > (sign_q ? q_neg_max : q_pos_max);
    end
endmodule

// File: rtl/booth_div.sv
// booth_div: signed 2W/W restoring divider, one quotient bit per clock, start/done handshake
module booth_div
    import booth_div_pkg::*;
#(
    parameter int WIDTH = booth_div_pkg::WIDTH
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);
    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dd;
    logic [WIDTH-1:0] dv, rem;
    logic sign_q, sign_r, zero_div;
    logic [DW-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag, q_fix, r_fix;
    logic ovf;
    logic [WIDTH:0] shifted;
    logic ge;
    assign shifted = {rem, dd[DW-1]};
    assign ge = shifted >= {1'b0, dv};
    div_sign_fix #(.W(WIDTH)) u_fix (
        .dividend(dividend),
        .divisor(divisor),
        .q_mag(dd),
        .r_mag(rem),
        .sign_q(sign_q),
        .sign_r(sign_r),
        .dividend_mag(dividend_mag),
        .divisor_mag(divisor_mag),
        .quotient(q_fix),
        .remainder(r_fix),
        .overflow(ovf)
    );
    // state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else state <= state_next;
    end
    // zero divisor skips iteration and goes straight to the sign/result stage
    always_comb begin
        state_next = state;
        state_next = (state == IDLE) ? (start ? ((divisor == '0) ? FIX : CALC) : IDLE)
                   : (state == CALC) ? ((cnt == LAST) ? FIX : CALC)
                   : IDLE;
    end
    // dd holds the dividend magnitude and fills with quotient bits from the bottom as it shifts out
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt         <= '0;
            dd          <= '0;
            dv          <= '0;
            rem         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero_div    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sign_q   <= dividend[DW-1] ^ divisor[WIDTH-1];
                    sign_r   <= dividend[DW-1];
                    zero_div <= divisor == '0;
                    dd       <= (divisor == '0) ? dividend : dividend_mag;
                    dv       <= divisor_mag;
                    rem      <= '0;
                    cnt      <= '0;
                    busy     <= 1'b1;
                end
                CALC: begin
                    rem <= ge ? shifted[WIDTH-1:0] - dv : shifted[WIDTH-1:0];
                    dd  <= {dd[DW-2:0], ge};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quotient    <= zero_div ? '0 : q_fix;
                    remainder   <= zero_div ? dd[WIDTH-1:0] : r_fix;
                    div_by_zero <= zero_div;
                    overflow    <= !zero_div && ovf;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
